// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      DROP,
      HOLD,
      ERR
   } fetchState_t;

   localparam int unsigned INSTR_W = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter plus the shadow copy of the address still owed by memory
// after a redirect abandons an in-flight fetch.
module fetch_pc_reg #(
   parameter int unsigned          PC_W     = 64,
   parameter logic [PC_W-1:0]      RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            loadTarget,
   input  logic            increment,
   input  logic            captureShadow,
   input  logic [PC_W-1:0] target,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] shadowPc
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc       <= RESET_PC;
         shadowPc <= RESET_PC;
      end else begin
         if (captureShadow)
            shadowPc <= pc;
         // A redirect always takes priority over the sequential step.
         if (loadTarget)
            pc <= target;
         else if (increment)
            pc <= pc + PC_W'(4);
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle fetch stage: single-outstanding memory reads, instruction
// register with valid/ready handoff, and branch redirect handling.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned     PC_W     = 64,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   output logic               mem_req,
   output logic [PC_W-1:0]    mem_addr,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               misaligned_err
);

   fetchState_t        state;
   logic               memReq;
   logic               instrValid;
   logic               errFlag;
   logic [INSTR_W-1:0] instrReg;
   logic [PC_W-1:0]    instrPcReg;
   logic [PC_W-1:0]    pc;
   logic [PC_W-1:0]    shadowPc;

   logic badTarget;
   logic goodRedirect;
   logic loadTarget;
   logic increment;
   logic captureShadow;

   always_comb begin
      badTarget     = redirect && (redirect_pc[1:0] != 2'b00);
      goodRedirect  = redirect && !badTarget && (state != ERR);
      loadTarget    = goodRedirect;
      increment     = (state == HOLD) && instr_ready && !redirect;
      captureShadow = (state == REQ) && goodRedirect && !mem_ack;
   end

   fetch_pc_reg #(
      .PC_W     (PC_W),
      .RESET_PC (RESET_PC)
   ) pcReg (
      .clk           (clk),
      .rst           (rst),
      .loadTarget    (loadTarget),
      .increment     (increment),
      .captureShadow (captureShadow),
      .target        (redirect_pc),
      .pc            (pc),
      .shadowPc      (shadowPc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         memReq     <= 1'b0;
         instrValid <= 1'b0;
         errFlag    <= 1'b0;
         instrReg   <= NOP_INSTR;
         instrPcReg <= RESET_PC;
      end else if ((state != ERR) && badTarget) begin
         state      <= ERR;
         errFlag    <= 1'b1;
         memReq     <= 1'b0;
         instrValid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state  <= REQ;
               memReq <= 1'b1;
            end
            REQ: begin
               // Ack together with a redirect drops the word and refetches at the target.
               if (mem_ack && !redirect) begin
                  instrReg   <= mem_rdata;
                  instrPcReg <= pc;
                  state      <= HOLD;
                  memReq     <= 1'b0;
                  instrValid <= 1'b1;
               end else if (redirect && !mem_ack) begin
                  state <= DROP;
               end
            end
            DROP: begin
               if (mem_ack)
                  state <= REQ;
            end
            HOLD: begin
               if (redirect || instr_ready) begin
                  state      <= REQ;
                  memReq     <= 1'b1;
                  instrValid <= 1'b0;
               end
            end
            ERR: ;
            default: begin
               state      <= IDLE;
               memReq     <= 1'b0;
               instrValid <= 1'b0;
            end
         endcase
      end
   end

   assign mem_req        = memReq;
   assign mem_addr       = (state == DROP) ? shadowPc : pc;
   assign instr          = instrReg;
   assign instr_pc       = instrPcReg;
   assign instr_valid    = instrValid;
   assign misaligned_err = errFlag;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus randomized checks of instr_fetch_unit against a
// transaction-level reference model of the fetch pipeline.
module tb_instr_fetch_unit;

   localparam int unsigned PC_W = 64;
   localparam logic [63:0] RST_PC = 64'h0;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [31:0] instr;
   logic [63:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        redirect = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        misaligned_err;

   int nChk = 0;
   int nErr = 0;

   instr_fetch_unit #(
      .PC_W     (PC_W),
      .RESET_PC (RST_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_ack        (mem_ack),
      .mem_rdata      (mem_rdata),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .misaligned_err (misaligned_err)
   );

   always #5 clk = ~clk;

   // Reference model: what the fetch stage owes, in transaction terms.
   bit          mStart, mFetch, mStale, mHave, mDead, mErr;
   logic [63:0] mPc, mStaleAddr, mInstrPc;
   logic [31:0] mInstr;

   function automatic logic [31:0] word(input logic [63:0] a);
      return a[31:0] ^ 32'h5A00_00C3 ^ {a[39:32], 24'h0};
   endfunction

   function automatic bit expReq();
      return mFetch || mStale;
   endfunction

   function automatic logic [63:0] expAddr();
      return mStale ? mStaleAddr : mPc;
   endfunction

   task automatic modelReset();
      mStart = 1; mFetch = 0; mStale = 0; mHave = 0; mDead = 0; mErr = 0;
      mPc = RST_PC; mStaleAddr = RST_PC; mInstrPc = RST_PC; mInstr = NOP;
   endtask

   task automatic modelStep(input bit ack, input bit rdy, input bit rd, input logic [63:0] tgt);
      if (mDead) return;
      if (rd && tgt[1:0] != 2'b00) begin
         mDead = 1; mErr = 1; mStart = 0; mFetch = 0; mStale = 0; mHave = 0;
      end else if (mStart) begin
         if (rd) mPc = tgt;
         mStart = 0; mFetch = 1;
      end else if (mFetch) begin
         if (ack && !rd) begin
            mInstr = word(mPc); mInstrPc = mPc; mHave = 1; mFetch = 0;
         end else if (rd && ack) begin
            mPc = tgt;
         end else if (rd) begin
            mStaleAddr = mPc; mPc = tgt; mStale = 1; mFetch = 0;
         end
      end else if (mStale) begin
         if (rd) mPc = tgt;
         if (ack) begin mStale = 0; mFetch = 1; end
      end else if (mHave) begin
         if (rd) begin mPc = tgt; mHave = 0; mFetch = 1; end
         else if (rdy) begin mPc = mPc + 64'd4; mHave = 0; mFetch = 1; end
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChk++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic checkOutputs();
      chk("mem_req", {63'd0, mem_req}, {63'd0, expReq()});
      if (expReq()) chk("mem_addr", mem_addr, expAddr());
      chk("instr_valid", {63'd0, instr_valid}, {63'd0, mHave});
      chk("instr", {32'd0, instr}, {32'd0, mInstr});
      chk("instr_pc", instr_pc, mInstrPc);
      chk("misaligned_err", {63'd0, misaligned_err}, {63'd0, mErr});
   endtask

   task automatic checkResetValues(input string tag);
      chk({tag, ".mem_req"}, {63'd0, mem_req}, 64'd0);
      chk({tag, ".mem_addr"}, mem_addr, RST_PC);
      chk({tag, ".instr"}, {32'd0, instr}, {32'd0, NOP});
      chk({tag, ".instr_pc"}, instr_pc, RST_PC);
      chk({tag, ".instr_valid"}, {63'd0, instr_valid}, 64'd0);
      chk({tag, ".misaligned_err"}, {63'd0, misaligned_err}, 64'd0);
   endtask

   // One cycle: compare at the falling edge, drive inputs, advance model, cross the rising edge.
   task automatic step(input bit ack, input bit rdy, input bit rd, input logic [63:0] tgt);
      @(negedge clk);
      checkOutputs();
      mem_ack     = ack;
      mem_rdata   = ack ? word(expAddr()) : $urandom;
      instr_ready = rdy;
      redirect    = rd;
      redirect_pc = tgt;
      modelStep(ack, rdy, rd, tgt);
      @(posedge clk);
   endtask

   task automatic releaseReset();
      @(posedge clk);
      #2 rst = 1'b1;
   endtask

   bit          memPending;
   int unsigned memLat;
   bit          ack, rdy, rd;
   logic [63:0] tgt;

   initial begin
      modelReset();
      #12;
      checkResetValues("reset");
      releaseReset();

      // Zero-wait memory, consumer always ready: 0x0, 0x4, 0x8 every other cycle.
      step(0, 1, 0, '0);
      for (int i = 0; i < 6; i++) step(expReq(), 1, 0, '0);

      // Memory 3-cycle latency, consumer stalls 2 cycles.
      step(0, 0, 0, '0); step(0, 0, 0, '0); step(0, 0, 0, '0);
      step(1, 0, 0, '0);
      step(0, 0, 0, '0); step(0, 0, 0, '0);
      step(0, 1, 0, '0);

      // Redirect in HOLD beats ready: next fetch 0x100.
      step(1, 0, 0, '0);
      step(0, 1, 1, 64'h100);
      step(1, 0, 0, '0);

      // Redirect to 0x8 then, while fetching 0x8, to 0x200: stale word dropped.
      step(0, 0, 1, 64'h8);
      step(0, 0, 1, 64'h200);
      step(0, 0, 0, '0);
      step(1, 0, 0, '0);
      step(1, 0, 0, '0);
      step(0, 1, 0, '0);

      // Redirect coinciding with ack in REQ: word discarded, refetch at target.
      step(1, 0, 1, 64'h300);
      step(1, 1, 0, '0);
      step(0, 1, 0, '0);

      // Randomized traffic with variable memory latency and aligned redirects.
      memPending = 0;
      for (int i = 0; i < 600; i++) begin
         ack = 0;
         if (expReq()) begin
            if (!memPending) begin memPending = 1; memLat = $urandom_range(0, 3); end
            if (memLat == 0) ack = 1; else memLat--;
         end
         rdy = ($urandom_range(0, 2) != 0);
         rd  = ($urandom_range(0, 9) == 0);
         tgt = {$urandom, $urandom} & ~64'h3;
         if ($urandom_range(0, 7) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF8;
         step(ack, rdy, rd, tgt);
         if (ack) memPending = 0;
      end

      // Misaligned target: error is sticky, later redirects ignored.
      step(0, 0, 1, 64'h102);
      for (int i = 0; i < 4; i++) step(i[0], 1, 1, 64'h40);
      step(0, 0, 0, '0);

      // Reset clears the error state.
      #2 rst = 1'b0;
      #1 checkResetValues("errclear");
      modelReset();
      releaseReset();
      step(0, 0, 0, '0);
      step(0, 0, 0, '0);
      step(0, 0, 0, '0);

      // Reset mid-request with ack still pending, then clean restart at RESET_PC.
      #2 rst = 1'b0;
      #1 checkResetValues("midreq");
      modelReset();
      releaseReset();
      step(0, 1, 0, '0);
      for (int i = 0; i < 4; i++) step(expReq(), 1, 0, '0);
      step(0, 0, 0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", nChk, nErr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "simulation did not finish");
   end

endmodule
